lgn_score_sequencer: RTL and testbench

Time-multiplexed class scorer for the logic-gate-network classifier output. On `start` it snapshots the net's flat output vector of CLASSES groups × N gate bits. It then popcounts one class group per cycle, stores the per-class score and tracks the running argmax. The block sits between the combinational `net` instance and the tile I/O, replacing a fully parallel popcount tree with one shared popcounter.

---
 rtl/lgn_pkg.sv | 15 +
 rtl/lgn_popcount.sv | 17 +
 rtl/lgn_score_sequencer.sv | 133 +++++++++++++
 tb/tb_lgn_score_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lgn_pkg.sv
// Shared defaults and FSM state type for the logic-gate-network class scorer.
package lgn_pkg;

  localparam int unsigned DefN       = 15;
  localparam int unsigned DefClasses = 10;
  localparam int unsigned DefSumW    = 4;
  localparam int unsigned DefClsW    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

endpackage

// File: rtl/lgn_popcount.sv
// Combinational population count of an N-bit group, zero-extended to SUM_W bits.
module lgn_popcount #(
  parameter int unsigned N     = 15,
  parameter int unsigned SUM_W = 4
) (
  input  logic [N-1:0]     bits,
  output logic [SUM_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + SUM_W'(bits[i]);
    end
  end

endmodule

// File: rtl/lgn_score_sequencer.sv
// Time-multiplexed class scorer: snapshots the net output, popcounts one class per
// cycle through a shared popcounter, stores per-class scores and tracks the argmax.
module lgn_score_sequencer
  import lgn_pkg::*;
#(
  parameter int unsigned N       = DefN,
  parameter int unsigned CLASSES = DefClasses,
  parameter int unsigned SUM_W   = DefSumW,
  parameter int unsigned CLS_W   = DefClsW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CLASSES*N-1:0] net_out,
  output logic                 busy,
  output logic                 done,
  output logic [CLS_W-1:0]     best_class,
  output logic [SUM_W-1:0]     best_score,
  input  logic [CLS_W-1:0]     score_sel,
  output logic [SUM_W-1:0]     score_rd
);

  state_e                 state_q, state_d;
  logic [CLASSES*N-1:0]   snap_q, snap_d;
  logic [CLS_W-1:0]       cls_q, cls_d;
  logic [CLS_W-1:0]       run_class_q, run_class_d;
  logic [SUM_W-1:0]       run_best_q, run_best_d;
  logic [CLS_W-1:0]       best_class_q, best_class_d;
  logic [SUM_W-1:0]       best_score_q, best_score_d;
  logic                   done_q, done_d;
  logic [SUM_W-1:0]       score_q [CLASSES];
  logic                   score_we;
  logic [N-1:0]           slice;
  logic [SUM_W-1:0]       pc;

  assign slice = snap_q[cls_q*N +: N];

  lgn_popcount #(
    .N     (N),
    .SUM_W (SUM_W)
  ) u_popcount (
    .bits  (slice),
    .count (pc)
  );

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    cls_d        = cls_q;
    run_class_d  = run_class_q;
    run_best_d   = run_best_q;
    best_class_d = best_class_q;
    best_score_d = best_score_q;
    done_d       = 1'b0;
    score_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          snap_d      = net_out;
          cls_d       = '0;
          run_best_d  = '0;
          run_class_d = '0;
          state_d     = StScan;
        end
      end
      StScan: begin
        score_we = 1'b1;
        // Strict compare keeps the lowest index on ties.
        if (cls_q == '0 || pc > run_best_q) begin
          run_best_d  = pc;
          run_class_d = cls_q;
        end
        if (cls_q == CLS_W'(CLASSES - 1)) begin
          state_d = StDone;
        end else begin
          cls_d = cls_q + 1'b1;
        end
      end
      StDone: begin
        best_class_d = run_class_q;
        best_score_d = run_best_q;
        done_d       = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      snap_q       <= '0;
      cls_q        <= '0;
      run_class_q  <= '0;
      run_best_q   <= '0;
      best_class_q <= '0;
      best_score_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      cls_q        <= cls_d;
      run_class_q  <= run_class_d;
      run_best_q   <= run_best_d;
      best_class_q <= best_class_d;
      best_score_q <= best_score_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CLASSES; i++) begin
        score_q[i] <= '0;
      end
    end else if (score_we) begin
      score_q[cls_q] <= pc;
    end
  end

  always_comb begin
    score_rd = '0;
    if (int'(score_sel) < int'(CLASSES)) begin
      score_rd = score_q[score_sel];
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign best_class = best_class_q;
  assign best_score = best_score_q;

endmodule

// File: tb/tb_lgn_score_sequencer.sv
// Self-checking bench: table of per-class counts with expected argmax, a scoreboard
// queue of expected results, and hand sequences for held start and mid-pass reset.
module tb_lgn_score_sequencer;

  localparam int N  = 15;
  localparam int CL = 10;
  localparam int SW = 4;
  localparam int CW = 4;
  localparam int W  = CL * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  net_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] best_class;
  logic [SW-1:0] best_score;
  logic [CW-1:0] score_sel;
  logic [SW-1:0] score_rd;

  always #5 clk = ~clk;

  lgn_score_sequencer #(
    .N       (N),
    .CLASSES (CL),
    .SUM_W   (SW),
    .CLS_W   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .net_out    (net_out),
    .busy       (busy),
    .done       (done),
    .best_class (best_class),
    .best_score (best_score),
    .score_sel  (score_sel),
    .score_rd   (score_rd)
  );

  typedef struct {
    logic [39:0] cnts;  // nibble c = number of ones in class c
    int          exp_cls;
    int          exp_score;
  } vec_t;

  typedef struct {
    int cls;
    int score;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Ones are scattered within each group so the slice selection is exercised.
  function automatic logic [W-1:0] build(input logic [39:0] cnts);
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < CL; c++) begin
      for (int b = 0; b < int'(cnts[c*4 +: 4]); b++) begin
        v[c*N + ((b * 7 + c) % N)] = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic readback(input string tag, input logic [39:0] cnts);
    for (int s = 0; s < 16; s++) begin
      score_sel = CW'(s);
      #1;
      chk($sformatf("%s score_rd[%0d]", tag, s), score_rd,
          (s < CL) ? 32'(cnts[s*4 +: 4]) : 32'd0);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, " best_class"}, best_class, e.cls);
      chk({tag, " best_score"}, best_score, e.score);
    end
  endtask

  // Called at a negedge; start is seen on edge 0, done expected after edge CL+1.
  task automatic run_pass(input string tag, input logic [39:0] cnts, input int ecls,
                          input int escore);
    int  busy_cnt;
    int  done_edge;
    bit  seen;
    exp_t e;
    net_out = build(cnts);
    start   = 1'b1;
    e.cls = ecls;
    e.score = escore;
    sb.push_back(e);
    busy_cnt  = 0;
    done_edge = -1;
    seen      = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (k == 4) net_out = ~net_out;  // post-capture change must not matter
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        done_edge = k;
        pop_check(tag);
      end
    end
    chk({tag, " done_seen"}, 32'(seen), 1);
    chk({tag, " done_edge"}, done_edge, CL + 1);
    chk({tag, " busy_cycles"}, busy_cnt, CL + 1);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, done, 0);
    readback(tag, cnts);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int dn;
    int edge1;
    int edge2;
    logic busy12;

    vecs[0] = '{cnts: 40'h0000000000, exp_cls: 0, exp_score: 0};
    vecs[1] = '{cnts: 40'h33F3333333, exp_cls: 7, exp_score: 15};
    vecs[2] = '{cnts: 40'h1432940914, exp_cls: 2, exp_score: 9};
    vecs[3] = '{cnts: 40'h9876543210, exp_cls: 9, exp_score: 9};
    vecs[4] = '{cnts: 40'h6666666666, exp_cls: 0, exp_score: 6};
    vecs[5] = '{cnts: 40'hF123E0567F, exp_cls: 0, exp_score: 15};

    rst = 1'b1;
    start = 1'b0;
    net_out = '0;
    score_sel = '0;
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset best_class", best_class, 0);
    chk("reset best_score", best_score, 0);
    readback("reset", 40'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_pass($sformatf("vec%0d", i), vecs[i].cnts, vecs[i].exp_cls, vecs[i].exp_score);
    end

    // Start held high across a whole pass, input swapped to all-ones mid-pass.
    begin
      exp_t e;
      net_out = build(vecs[1].cnts);
      start = 1'b1;
      e.cls = 7;
      e.score = 15;
      sb.push_back(e);
      dn = 0;
      edge1 = -1;
      busy12 = 1'b0;
      for (int k = 0; k <= 12; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (k == 3) net_out = '1;
        if (done) begin
          dn++;
          edge1 = k;
          pop_check("held first");
        end
        if (k == 12) busy12 = busy;
      end
      start = 1'b0;
      chk("held done_count", dn, 1);
      chk("held done_edge", edge1, CL + 1);
      chk("held restart_busy", busy12, 1);
      e.cls = 0;
      e.score = 15;
      sb.push_back(e);
      edge2 = -1;
      for (int k = 13; k < 60 && edge2 < 0; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (done) begin
          edge2 = k;
          pop_check("held second");
        end
      end
      chk("held second_done_edge", edge2, 2 * (CL + 1) + 1);
      readback("held second", 40'hFFFFFFFFFF);
    end

    // Reset mid-scan aborts the pass and clears every score.
    @(negedge clk);
    net_out = build(vecs[2].cnts);
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst best_class", best_class, 0);
    chk("midrst best_score", best_score, 0);
    readback("midrst", 40'h0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dn++;
    end
    chk("midrst no_done", dn, 0);
    run_pass("after_rst", vecs[2].cnts, 2, 9);

    chk("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
